// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared definitions for the instruction fetch stage.
//   - Address/word widths, in-flight limit
//   - Fetch FSM state type
//   - word_align(): clear the byte-offset bits of an address
package fetch_unit_pkg;

  localparam int unsigned RISCV_ADDR_WIDTH = 32;
  localparam int unsigned RISCV_WORD_WIDTH = 32;
  localparam int unsigned RISCV_FETCH_MAX_OUTSTANDING = 2;

  typedef enum logic {
    FETCH_BOOT,
    FETCH_RUN
  } fetch_state_e;

  function automatic logic [RISCV_ADDR_WIDTH-1:0] word_align(
    input logic [RISCV_ADDR_WIDTH-1:0] addr
  );
    return {addr[RISCV_ADDR_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// fetch_fifo: 2-entry synchronous skid FIFO of {address, data} pairs.
//   clk, rst_n            clock, asynchronous active-low reset
//   push_i, push_addr_i,
//   push_data_i           write an entry
//   pop_i                 drop the head entry
//   flush_i               empty the FIFO (wins over push/pop)
//   head_addr_o/data_o    head entry contents
//   empty_o, count_o      occupancy
// Push into a full FIFO without a pop is never requested by the fetch unit.
module fetch_fifo
  import fetch_unit_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push_i,
  input  logic [RISCV_ADDR_WIDTH-1:0] push_addr_i,
  input  logic [RISCV_WORD_WIDTH-1:0] push_data_i,
  input  logic                        pop_i,
  input  logic                        flush_i,
  output logic [RISCV_ADDR_WIDTH-1:0] head_addr_o,
  output logic [RISCV_WORD_WIDTH-1:0] head_data_o,
  output logic                        empty_o,
  output logic [1:0]                  count_o
);

  logic [RISCV_ADDR_WIDTH-1:0] r_addr_mem [2];
  logic [RISCV_WORD_WIDTH-1:0] r_data_mem [2];
  logic                        r_wptr;
  logic                        r_rptr;
  logic [1:0]                  r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else if (flush_i) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (push_i) r_wptr <= ~r_wptr;
      if (pop_i)  r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, push_i} - {1'b0, pop_i};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_mem[0] <= '0;
      r_addr_mem[1] <= '0;
      r_data_mem[0] <= '0;
      r_data_mem[1] <= '0;
    end else if (push_i && !flush_i) begin
      r_addr_mem[r_wptr] <= push_addr_i;
      r_data_mem[r_wptr] <= push_data_i;
    end
  end

  assign head_addr_o = r_addr_mem[r_rptr];
  assign head_data_o = r_data_mem[r_rptr];
  assign empty_o     = (r_count == 2'd0);
  assign count_o     = r_count;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding the realign buffer.
//   clk, rst_n                 clock, asynchronous active-low reset
//   redirect_i/addr_i          one-cycle restart request and new (halfword) PC
//   imem_req_o/addr_o          word-aligned fetch request, held until granted
//   imem_gnt_i                 request accepted
//   imem_rvalid_i/rdata_i      in-order response
//   buf_write_en_o, buf_instr_o, buf_addr_o   word handed to realign buffer
//   buf_full_i                 realign buffer cannot accept a word
//   buf_flush_o                reset realign buffer indices (on redirect)
//   buf_skip_half_o            first word after redirect starts at upper half
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = RISCV_FETCH_MAX_OUTSTANDING
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        redirect_i,
  input  logic [RISCV_ADDR_WIDTH-1:0] redirect_addr_i,
  output logic                        imem_req_o,
  output logic [RISCV_ADDR_WIDTH-1:0] imem_addr_o,
  input  logic                        imem_gnt_i,
  input  logic                        imem_rvalid_i,
  input  logic [RISCV_WORD_WIDTH-1:0] imem_rdata_i,
  output logic                        buf_write_en_o,
  output logic [RISCV_WORD_WIDTH-1:0] buf_instr_o,
  output logic [RISCV_ADDR_WIDTH-1:0] buf_addr_o,
  input  logic                        buf_full_i,
  output logic                        buf_flush_o,
  output logic                        buf_skip_half_o
);

  localparam logic [RISCV_ADDR_WIDTH-1:0] BootPc = {BOOT_ADDR[31:2], 2'b00};

  fetch_state_e                r_state;
  logic [RISCV_ADDR_WIDTH-1:0] r_fetch_pc;
  logic [RISCV_ADDR_WIDTH-1:0] r_resp_addr;
  logic [1:0]                  r_outstanding;
  logic [1:0]                  r_discard;
  logic                        r_skip_pending;

  logic                        w_fifo_empty;
  logic [1:0]                  w_fifo_count;
  logic [RISCV_ADDR_WIDTH-1:0] w_head_addr;
  logic [RISCV_WORD_WIDTH-1:0] w_head_data;
  logic [2:0]                  w_inflight_sum;
  logic                        w_grant;
  logic                        w_push;
  logic [1:0]                  w_outstanding_d;
  logic                        w_unused;

  assign w_unused = redirect_addr_i[0];

  // Stale responses still awaiting drop count against the budget as well,
  // which is what keeps the 2-entry FIFO from overflowing.
  assign w_inflight_sum = {1'b0, r_outstanding} + {1'b0, w_fifo_count} + {1'b0, r_discard};
  assign imem_req_o     = (r_state == FETCH_RUN) &&
                          ({29'd0, w_inflight_sum} < MAX_OUTSTANDING);
  assign imem_addr_o    = r_fetch_pc;
  assign w_grant        = imem_req_o && imem_gnt_i;

  // A response landing in the redirect cycle belongs to the old stream.
  assign w_push = imem_rvalid_i && (r_discard == 2'd0) && !redirect_i;

  always_comb begin
    w_outstanding_d = r_outstanding;
    if (w_grant && !imem_rvalid_i) begin
      w_outstanding_d = r_outstanding + 2'd1;
    end else if (!w_grant && imem_rvalid_i) begin
      w_outstanding_d = r_outstanding - 2'd1;
    end
  end

  assign buf_write_en_o  = !w_fifo_empty && !buf_full_i && !redirect_i;
  assign buf_instr_o     = w_head_data;
  assign buf_addr_o      = w_head_addr;
  assign buf_flush_o     = redirect_i;
  assign buf_skip_half_o = r_skip_pending && buf_write_en_o;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= FETCH_BOOT;
      r_fetch_pc     <= BootPc;
      r_resp_addr    <= BootPc;
      r_outstanding  <= 2'd0;
      r_discard      <= 2'd0;
      r_skip_pending <= 1'b0;
    end else begin
      unique case (r_state)
        FETCH_BOOT: r_state <= FETCH_RUN;
        FETCH_RUN:  r_state <= FETCH_RUN;
      endcase

      r_outstanding <= w_outstanding_d;

      if (redirect_i) begin
        // Everything still in flight (including a grant this cycle) is stale.
        r_discard      <= w_outstanding_d;
        r_fetch_pc     <= word_align(redirect_addr_i);
        r_resp_addr    <= word_align(redirect_addr_i);
        r_skip_pending <= redirect_addr_i[1];
      end else begin
        if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_push)  r_resp_addr <= r_resp_addr + 32'd4;
        if (imem_rvalid_i && (r_discard != 2'd0)) r_discard <= r_discard - 2'd1;
        if (buf_write_en_o) r_skip_pending <= 1'b0;
      end
    end
  end

  fetch_fifo u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (w_push),
    .push_addr_i (r_resp_addr),
    .push_data_i (imem_rdata_i),
    .pop_i       (buf_write_en_o),
    .flush_i     (redirect_i),
    .head_addr_o (w_head_addr),
    .head_data_o (w_head_data),
    .empty_o     (w_fifo_empty),
    .count_o     (w_fifo_count)
  );

endmodule
